// File: rtl/uart_tx_ctrl_if.sv
// Handshake and control bundle between the TX frame controller and the TX datapath.
interface uart_tx_ctrl_if;
  logic       Data_Valid;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       data_load;
  logic       ser_en;
  logic [1:0] mux_sel;
  logic       par_typ_q;
  logic       busy;

  // Requester side: raises byte requests and supplies the parity configuration.
  modport master (
    output Data_Valid,
    output PAR_EN,
    output PAR_TYP,
    input  data_load,
    input  ser_en,
    input  mux_sel,
    input  par_typ_q,
    input  busy
  );

  // Controller side.
  modport slave (
    input  Data_Valid,
    input  PAR_EN,
    input  PAR_TYP,
    output data_load,
    output ser_en,
    output mux_sel,
    output par_typ_q,
    output busy
  );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART TX frame sequencer: start, data, optional parity and stop phases.
module uart_tx_ctrl #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic          CLK,
  input  logic          RST,
  uart_tx_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  localparam logic [1:0] MUX_STOP   = 2'b00;
  localparam logic [1:0] MUX_START  = 2'b01;
  localparam logic [1:0] MUX_DATA   = 2'b10;
  localparam logic [1:0] MUX_PARITY = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             par_en_q;
  logic             par_typ_reg;
  logic             accept;
  logic             ser_en_reg;
  logic [1:0]       mux_sel_reg;
  logic             busy_reg;
  logic             ser_en_next;
  logic [1:0]       mux_sel_next;
  logic             busy_next;

  // A request is taken only when the line is free or the current frame is ending.
  assign accept        = bus.Data_Valid && ((state == IDLE) || (state == STOP));
  assign bus.data_load = accept;
  assign bus.ser_en    = ser_en_reg;
  assign bus.mux_sel   = mux_sel_reg;
  assign bus.busy      = busy_reg;
  assign bus.par_typ_q = par_typ_reg;

  // Next-state, bit-counter and next-output decode.
  always_comb begin
    next_state   = state;
    cnt_next     = cnt;
    ser_en_next  = 1'b0;
    mux_sel_next = MUX_STOP;
    busy_next    = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          next_state = START;
          cnt_next   = '0;
        end
      end
      START: begin
        next_state = DATA;
      end
      DATA: begin
        if (cnt == CNT_LAST) begin
          next_state = par_en_q ? PARITY : STOP;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      PARITY: begin
        next_state = STOP;
      end
      STOP: begin
        if (accept) begin
          next_state = START;
          cnt_next   = '0;
        end else begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
        cnt_next   = '0;
      end
    endcase

    // Outputs are registered, so decode them from the state being entered.
    case (next_state)
      START: begin
        mux_sel_next = MUX_START;
        busy_next    = 1'b1;
      end
      DATA: begin
        mux_sel_next = MUX_DATA;
        ser_en_next  = 1'b1;
        busy_next    = 1'b1;
      end
      PARITY: begin
        mux_sel_next = MUX_PARITY;
        busy_next    = 1'b1;
      end
      STOP: begin
        mux_sel_next = MUX_STOP;
        busy_next    = 1'b1;
      end
      default: begin
        mux_sel_next = MUX_STOP;
      end
    endcase
  end

  // State, counter, latched parity configuration and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      cnt         <= '0;
      par_en_q    <= 1'b0;
      par_typ_reg <= 1'b0;
      ser_en_reg  <= 1'b0;
      mux_sel_reg <= MUX_STOP;
      busy_reg    <= 1'b0;
    end else begin
      state       <= next_state;
      cnt         <= cnt_next;
      ser_en_reg  <= ser_en_next;
      mux_sel_reg <= mux_sel_next;
      busy_reg    <= busy_next;
      if (accept) begin
        par_en_q    <= bus.PAR_EN;
        par_typ_reg <= bus.PAR_TYP;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: directed vector table, corner sequences, random traffic.
module tb_uart_tx_ctrl;

  localparam int W = 8;

  logic CLK;
  logic RST;
  uart_tx_ctrl_if bus ();

  uart_tx_ctrl #(.DATA_WIDTH(W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic       dv;
    logic       pe;
    logic       pt;
    logic [5:0] exp;   // {data_load, ser_en, mux_sel, busy, par_typ_q}
  } vec_t;

  vec_t tbl[$];

  int tests = 0;
  int fails = 0;
  int n_load, n_busy, n_ser;

  // Frame-position reference model: position 0 is START, 1..W data,
  // W+1 parity when enabled, last position STOP.
  bit m_act;
  int m_pos;
  int m_len;
  bit m_pen;
  bit m_ptyp;

  function automatic logic [5:0] outs();
    return {bus.data_load, bus.ser_en, bus.mux_sel, bus.busy, bus.par_typ_q};
  endfunction

  function automatic logic [5:0] model_exp(input logic dv);
    logic       ld, se, b;
    logic [1:0] mx;
    ld = 1'b0; se = 1'b0; b = 1'b0; mx = 2'b00;
    if (!m_act) begin
      ld = dv;
    end else begin
      b = 1'b1;
      if (m_pos == 0) mx = 2'b01;
      else if (m_pos <= W) begin mx = 2'b10; se = 1'b1; end
      else if (m_pos == m_len - 1) begin mx = 2'b00; ld = dv; end
      else mx = 2'b11;
    end
    return {ld, se, mx, b, logic'(m_ptyp)};
  endfunction

  task automatic model_adv(input logic r, input logic dv, input logic pe, input logic pt);
    if (r) begin
      m_act = 0; m_pos = 0; m_pen = 0; m_ptyp = 0;
    end else if (dv && (!m_act || m_pos == m_len - 1)) begin
      m_act = 1; m_pos = 0; m_pen = pe; m_ptyp = pt;
      m_len = 2 + W + (pe ? 1 : 0);
    end else if (m_act) begin
      m_pos++;
      if (m_pos >= m_len) m_act = 0;
    end
  endtask

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: {load,ser,mux,busy,ptq} got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: apply inputs, compare against the model mid-cycle, then advance.
  task automatic cycle(input logic r, input logic dv, input logic pe, input logic pt, input string name);
    RST = r; bus.Data_Valid = dv; bus.PAR_EN = pe; bus.PAR_TYP = pt;
    #2;
    check(name, outs(), model_exp(dv));
    if (bus.data_load === 1'b1) n_load++;
    if (bus.busy === 1'b1) n_busy++;
    if (bus.ser_en === 1'b1) n_ser++;
    @(posedge CLK);
    model_adv(r, dv, pe, pt);
    #1;
  endtask

  task automatic clear_tallies();
    n_load = 0; n_busy = 0; n_ser = 0;
  endtask

  task automatic add_vec(input logic dv, input logic pe, input logic pt, input logic [5:0] exp);
    vec_t v;
    v.dv = dv; v.pe = pe; v.pt = pt; v.exp = exp;
    tbl.push_back(v);
  endtask

  initial begin
    // No-parity frame from IDLE, then a parity frame with config toggled mid-frame.
    add_vec(1, 0, 0, 6'b1_0_00_0_0);
    add_vec(0, 0, 0, 6'b0_0_01_1_0);
    for (int i = 0; i < W; i++) add_vec(0, 0, 0, 6'b0_1_10_1_0);
    add_vec(0, 0, 0, 6'b0_0_00_1_0);
    add_vec(0, 0, 0, 6'b0_0_00_0_0);
    add_vec(1, 1, 1, 6'b1_0_00_0_0);
    add_vec(0, 1, 1, 6'b0_0_01_1_1);
    for (int i = 0; i < W; i++) begin
      logic b;
      b = logic'(i % 2);
      add_vec(0, b, ~b, 6'b0_1_10_1_1);
    end
    add_vec(0, 0, 0, 6'b0_0_11_1_1);
    add_vec(0, 0, 0, 6'b0_0_00_1_1);
    add_vec(0, 0, 0, 6'b0_0_00_0_1);

    RST = 1'b1; bus.Data_Valid = 1'b0; bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0;
    m_act = 0; m_pos = 0; m_len = 2 + W; m_pen = 0; m_ptyp = 0;
    repeat (2) @(posedge CLK);
    model_adv(1, 0, 0, 0);
    #1;
    RST = 1'b0;
    #2;
    check("reset_state", outs(), 6'b0);

    // Idle hold.
    clear_tallies();
    for (int i = 0; i < 20; i++) cycle(0, 0, 0, 0, "idle_hold");
    check_int("idle_load_count", n_load, 0);
    check_int("idle_busy_count", n_busy, 0);

    // Directed vector table.
    foreach (tbl[i]) begin
      RST = 1'b0; bus.Data_Valid = tbl[i].dv; bus.PAR_EN = tbl[i].pe; bus.PAR_TYP = tbl[i].pt;
      #2;
      check($sformatf("vec%0d", i), outs(), tbl[i].exp);
      @(posedge CLK);
      model_adv(0, tbl[i].dv, tbl[i].pe, tbl[i].pt);
      #1;
    end

    // Back-to-back frames with Data_Valid held high.
    clear_tallies();
    for (int i = 0; i < 40; i++) cycle(0, 1, 0, 0, "b2b");
    check_int("b2b_load_count", n_load, 4);
    check_int("b2b_busy_count", n_busy, 39);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, "b2b_drain");

    // Request during the 4th data cycle is ignored.
    clear_tallies();
    cycle(0, 1, 0, 0, "ign_accept");
    cycle(0, 0, 0, 0, "ign_start");
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, "ign_data");
    cycle(0, 1, 0, 0, "ign_data4");
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, "ign_tail");
    check_int("ign_load_count", n_load, 1);
    check_int("ign_busy_count", n_busy, 10);

    // Reset during the 5th data cycle of a parity frame.
    cycle(0, 1, 1, 1, "rst_accept");
    cycle(0, 0, 1, 1, "rst_start");
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 1, "rst_data");
    cycle(1, 0, 1, 1, "rst_data5");
    RST = 1'b0; bus.Data_Valid = 1'b0;
    #2;
    check("rst_after", outs(), 6'b0);
    clear_tallies();
    cycle(0, 1, 0, 0, "rst_fresh_accept");
    for (int i = 0; i < 11; i++) cycle(0, 0, 0, 0, "rst_fresh");
    check_int("rst_fresh_busy", n_busy, 10);
    check_int("rst_fresh_ser", n_ser, 8);
    check_int("rst_fresh_load", n_load, 1);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic r, dv, pe, pt;
      r  = ($urandom_range(63) == 0);
      dv = ($urandom_range(2) == 0);
      pe = logic'($urandom_range(1));
      pt = logic'($urandom_range(1));
      cycle(r, dv, pe, pt, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
